// File: rtl/pipe_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, selects the next PC from decode-stage redirects and fetches
// from a wait-stated instruction memory over a req/ack handshake. A one-entry
// fetch buffer keeps a word that arrives during a stall, and a one-entry
// redirect latch keeps a branch target that decode presents while the delay
// slot is still being fetched.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  logic [31:0] fbuf;
  logic        fbuf_v;
  logic [31:0] redir_pc;
  logic        redir_v;

  logic        avail;
  logic        adv;
  logic        bubble;
  logic        stall;
  logic [31:0] word;
  logic [31:0] pc4;
  logic [31:0] sel_target;
  logic [31:0] target_al;
  logic [31:0] npc;

  // An ack that lands while the buffer is full is a protocol error; the
  // buffered word wins and the stray ack is simply not used.
  assign avail  = imem_ack | fbuf_v;
  assign word   = fbuf_v ? fbuf : imem_rdata;
  assign adv    = wpcir & avail;
  assign stall  = ~wpcir;
  assign bubble = wpcir & ~avail;
  assign pc4    = pc + 32'd4;

  // Request stays high until a word is parked in the buffer; it is gated by
  // clrn so that a reset abandons an outstanding request immediately.
  assign imem_req  = clrn & ~fbuf_v;
  assign imem_addr = pc;

  // Target selected by decode's pcsource (00 falls through to pc+4).
  always_comb begin
    sel_target = pc4;
    case (pcsource)
      2'b01:   sel_target = bpc;
      2'b10:   sel_target = ra;
      2'b11:   sel_target = jpc;
      default: sel_target = pc4;
    endcase
  end

  // Instruction addresses are word aligned, so the low two bits are dropped.
  assign target_al = sel_target & 32'hFFFF_FFFC;

  // A latched redirect takes precedence over whatever decode presents now.
  assign npc = redir_v ? redir_pc : target_al;

  // PC and IF/ID register: load on advance, inject a bubble when memory is
  // slow, hold everything during a stall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc     <= RESET_PC;
      dpc4   <= 32'h0000_0000;
      inst   <= NOP_INST;
      dvalid <= 1'b0;
    end else if (adv) begin
      pc     <= npc;
      dpc4   <= pc4;
      inst   <= word;
      dvalid <= 1'b1;
    end else if (bubble) begin
      inst   <= NOP_INST;
      dvalid <= 1'b0;
    end
  end

  // Fetch buffer: park a word that completes during a stall so the memory
  // request can drop; consumed by the next advance.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fbuf   <= 32'h0000_0000;
      fbuf_v <= 1'b0;
    end else if (adv) begin
      fbuf_v <= 1'b0;
    end else if (stall && imem_ack && !fbuf_v) begin
      fbuf   <= imem_rdata;
      fbuf_v <= 1'b1;
    end
  end

  // Redirect latch: a branch resolved while its delay slot is still in
  // flight is remembered and applied when the delay slot finally advances.
  // An already-latched redirect is never overwritten.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      redir_pc <= 32'h0000_0000;
      redir_v  <= 1'b0;
    end else if (adv) begin
      redir_v <= 1'b0;
    end else if (bubble && (pcsource != 2'b00) && !redir_v) begin
      redir_pc <= target_al;
      redir_v  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// Self-checking bench for pipe_fetch: directed vector table, a reset-in-wait
// sequence, and randomized traffic against a queue-based reference model.
module tb_pipe_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clrn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .clrn(clrn), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .ra(ra),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  ps;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_inst;
    logic [31:0] e_dpc4;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [1:0] ps, logic [31:0] tgt, logic ack,
                              logic [31:0] rd, logic e_req, logic [31:0] e_addr,
                              logic e_dv, logic [31:0] e_inst, logic [31:0] e_dpc4,
                              logic [31:0] e_pc);
    vec_t v;
    v.w = w; v.ps = ps; v.tgt = tgt; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv;
    v.e_inst = e_inst; v.e_dpc4 = e_dpc4; v.e_pc = e_pc;
    return v;
  endfunction

  // Reference model: architectural view of the stage. The fetch buffer and
  // the pending redirect are at most one-entry queues.
  logic [31:0] m_pc, m_dpc4, m_inst;
  logic        m_dv;
  logic [31:0] m_buf[$];
  logic [31:0] m_redir[$];

  task automatic model_reset();
    m_pc = RESET_PC; m_dpc4 = 0; m_inst = NOP_INST; m_dv = 0;
    m_buf.delete(); m_redir.delete();
  endtask

  function automatic logic [31:0] target_of(logic [1:0] ps, logic [31:0] cur_pc,
                                            logic [31:0] b, logic [31:0] j, logic [31:0] r);
    logic [31:0] t;
    case (ps)
      2'd1: t = b;
      2'd2: t = r;
      2'd3: t = j;
      default: t = cur_pc + 4;
    endcase
    return {t[31:2], 2'b00};
  endfunction

  task automatic model_step(input logic w, input logic [1:0] ps, input logic [31:0] b,
                            input logic [31:0] j, input logic [31:0] r,
                            input logic ack, input logic [31:0] rd);
    logic        have;
    logic [31:0] wd;
    have = (m_buf.size() > 0) || ack;
    wd   = (m_buf.size() > 0) ? m_buf[0] : rd;
    if (w && have) begin
      m_dpc4 = m_pc + 4;
      m_inst = wd;
      m_dv   = 1;
      m_buf.delete();
      if (m_redir.size() > 0) m_pc = m_redir.pop_front();
      else m_pc = target_of(ps, m_pc, b, j, r);
    end else if (!w) begin
      if (ack && m_buf.size() == 0) m_buf.push_back(rd);
    end else begin
      m_inst = NOP_INST;
      m_dv   = 0;
      if (ps != 2'd0 && m_redir.size() == 0) m_redir.push_back(target_of(ps, m_pc, b, j, r));
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] rb, rj, rr, rdat;
    logic        rw, rack;
    logic [1:0]  rps;

    // Directed vectors (from reset, PC=0).
    //           w  ps   tgt            ack rd             req addr           dv inst           dpc4           pc
    vecs.push_back(mk(1, 2'd0, 32'h0,        1, 32'hA000_0000, 1, 32'h0,        1, 32'hA000_0000, 32'h4,         32'h4));
    vecs.push_back(mk(1, 2'd0, 32'h0,        1, 32'hA000_0001, 1, 32'h4,        1, 32'hA000_0001, 32'h8,         32'h8));
    vecs.push_back(mk(1, 2'd0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h8,        0, NOP_INST,      32'h8,         32'h8));
    vecs.push_back(mk(1, 2'd0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h8,        0, NOP_INST,      32'h8,         32'h8));
    vecs.push_back(mk(1, 2'd0, 32'h0,        1, 32'hA000_0002, 1, 32'h8,        1, 32'hA000_0002, 32'hC,         32'hC));
    vecs.push_back(mk(0, 2'd0, 32'h0,        1, 32'h1234_5678, 1, 32'hC,        1, 32'hA000_0002, 32'hC,         32'hC));
    vecs.push_back(mk(0, 2'd0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'hC,        1, 32'hA000_0002, 32'hC,         32'hC));
    vecs.push_back(mk(0, 2'd1, 32'h500,      0, 32'hDEAD_BEEF, 0, 32'hC,        1, 32'hA000_0002, 32'hC,         32'hC));
    vecs.push_back(mk(1, 2'd0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'hC,        1, 32'h1234_5678, 32'h10,        32'h10));
    vecs.push_back(mk(1, 2'd1, 32'h100,      1, 32'hA000_0003, 1, 32'h10,       1, 32'hA000_0003, 32'h14,        32'h100));
    vecs.push_back(mk(1, 2'd0, 32'h0,        1, 32'hA000_0004, 1, 32'h100,      1, 32'hA000_0004, 32'h104,       32'h104));
    vecs.push_back(mk(1, 2'd1, 32'h200,      0, 32'hDEAD_BEEF, 1, 32'h104,      0, NOP_INST,      32'h104,       32'h104));
    vecs.push_back(mk(1, 2'd0, 32'h300,      0, 32'hDEAD_BEEF, 1, 32'h104,      0, NOP_INST,      32'h104,       32'h104));
    vecs.push_back(mk(1, 2'd1, 32'h300,      0, 32'hDEAD_BEEF, 1, 32'h104,      0, NOP_INST,      32'h104,       32'h104));
    vecs.push_back(mk(1, 2'd0, 32'h300,      1, 32'hA000_0005, 1, 32'h104,      1, 32'hA000_0005, 32'h108,       32'h200));
    vecs.push_back(mk(1, 2'd2, 32'h203,      1, 32'hA000_0006, 1, 32'h200,      1, 32'hA000_0006, 32'h204,       32'h200));
    vecs.push_back(mk(1, 2'd3, 32'h400,      1, 32'hA000_0007, 1, 32'h200,      1, 32'hA000_0007, 32'h204,       32'h400));
    vecs.push_back(mk(1, 2'd0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h400,      0, NOP_INST,      32'h204,       32'h400));
    vecs.push_back(mk(1, 2'd3, 32'hFFFF_FFFF,1, 32'hA000_0008, 1, 32'h400,      1, 32'hA000_0008, 32'h404,       32'hFFFF_FFFC));
    vecs.push_back(mk(1, 2'd0, 32'h0,        1, 32'hA000_0009, 1, 32'hFFFF_FFFC,1, 32'hA000_0009, 32'h0,         32'h0));

    clrn = 0; wpcir = 0; pcsource = 0; bpc = 0; jpc = 0; ra = 0;
    imem_ack = 0; imem_rdata = 0;
    #12;
    chk("reset_req",    {31'b0, imem_req}, 32'h0);
    chk("reset_pc",     pc, RESET_PC);
    chk("reset_dpc4",   dpc4, 32'h0);
    chk("reset_inst",   inst, NOP_INST);
    chk("reset_dvalid", {31'b0, dvalid}, 32'h0);
    @(negedge clk);
    clrn = 1;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      wpcir = v.w; pcsource = v.ps; bpc = v.tgt; jpc = v.tgt; ra = v.tgt;
      imem_ack = v.ack; imem_rdata = v.rd;
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, imem_req}, {31'b0, v.e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, v.e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_dvalid", i), {31'b0, dvalid}, {31'b0, v.e_dv});
      chk($sformatf("v%0d_inst", i),   inst, v.e_inst);
      chk($sformatf("v%0d_dpc4", i),   dpc4, v.e_dpc4);
      chk($sformatf("v%0d_pc", i),     pc, v.e_pc);
    end

    // Reset pulsed in the middle of a wait-stated fetch.
    @(negedge clk);
    wpcir = 1; pcsource = 0; imem_ack = 0;
    @(posedge clk); #2;
    chk("midwait_req_before", {31'b0, imem_req}, 32'h1);
    clrn = 0;
    #1;
    chk("midwait_req",    {31'b0, imem_req}, 32'h0);
    chk("midwait_pc",     pc, RESET_PC);
    chk("midwait_dvalid", {31'b0, dvalid}, 32'h0);
    chk("midwait_inst",   inst, NOP_INST);
    @(negedge clk);
    wpcir = 0;
    clrn = 1;
    model_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rw   = ($urandom_range(0, 3) != 0);
      rps  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) rps = 2'd0;
      rb   = $urandom; rj = $urandom; rr = $urandom; rdat = $urandom;
      rack = (m_buf.size() == 0) && ($urandom_range(0, 2) != 0);
      wpcir = rw; pcsource = rps; bpc = rb; jpc = rj; ra = rr;
      imem_ack = rack; imem_rdata = rdat;
      #1;
      chk("rnd_req",  {31'b0, imem_req}, {31'b0, (m_buf.size() == 0)});
      chk("rnd_addr", imem_addr, m_pc);
      model_step(rw, rps, rb, rj, rr, rack, rdat);
      @(posedge clk); #1;
      chk("rnd_pc",     pc, m_pc);
      chk("rnd_dpc4",   dpc4, m_dpc4);
      chk("rnd_inst",   inst, m_inst);
      chk("rnd_dvalid", {31'b0, dvalid}, {31'b0, m_dv});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. Holds the PC, selects the next PC from decode-stage redirects, and fetches from a wait-stated instruction memory with a req/ack handshake. Delivers dpc4/inst to decode, inserting NOP bubbles when memory is slow. Branches are delayed (one delay slot); a redirect that arrives while the delay slot is still being fetched is latched, not lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0000, instruction word injected as a bubble

Ports:
clk  in  1  clock, all state updates on rising edge
clrn  in  1  asynchronous active-low reset
wpcir  in  1  1 = PC and IF/ID may update; 0 = stall (hazard unit)
pcsource  in  2  from decode: 00 pc+4, 01 bpc, 10 ra, 11 jpc
bpc  in  32  branch target from decode
jpc  in  32  jump target from decode
ra  in  32  register target (jr) from decode
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  instruction word, valid when imem_ack=1
imem_ack  in  1  one-cycle completion strobe for the current request
pc  out  32  current fetch PC
dpc4  out  32  IF/ID: PC+4 of the instruction in decode
inst  out  32  IF/ID: instruction in decode
dvalid  out  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (clrn=0, async): pc=RESET_PC; dpc4=0; inst=NOP_INST; dvalid=0; fbuf_v=0; redir_v=0; imem_req=0 while clrn=0.
- Fetch buffer: fbuf (32b) + fbuf_v. imem_req = ~fbuf_v (after reset release). imem_addr = pc. pc changes only on advance, so addr is stable throughout a request.
- avail = imem_ack | fbuf_v; word = fbuf_v ? fbuf : imem_rdata. imem_ack while fbuf_v=1 is a protocol error (ignored).
- Advance (adv = wpcir & avail): dpc4<=pc+4; inst<=word; dvalid<=1; fbuf_v<=0; pc<=npc.
- npc priority: redir_v -> redir_pc (clear redir_v); else pcsource 01 bpc, 10 ra, 11 jpc, 00 pc+4. npc[1:0] forced to 00.
- Stall (wpcir=0): pc, dpc4, inst, dvalid, redir_v held. If imem_ack, capture imem_rdata into fbuf, fbuf_v<=1 (imem_req drops next cycle). pcsource ignored (decode re-presents it after the stall).
- Bubble (wpcir=1 & ~avail): inst<=NOP_INST; dvalid<=0; dpc4 held; pc held. If pcsource!=00: redir_pc<=selected target (low bits 00), redir_v<=1; the redirect is applied on the next advance (delay-slot fetch completing).
- While dvalid=0, decode presents pcsource=00; a non-zero pcsource then is ignored if redir_v=1 (existing latch wins).
- Latency: zero-wait memory (ack in cycle of req) -> one instruction per cycle, word enters IF/ID at edge ending the ack cycle. N wait cycles -> N bubbles.
- Reset mid-request: outstanding request abandoned, req deasserts immediately; memory must tolerate.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

Test Plan:
- Reset then zero-wait memory, wpcir=1, pcsource=00 -> imem_addr 0,4,8,...; dpc4 4,8,12; dvalid=1 from 2nd edge after release.
- Memory 2 wait cycles per fetch -> inst=NOP_INST, dvalid=0 for 2 cycles between each real instruction; pc advances once per 3 cycles.
- wpcir=0 for 3 cycles while ack arrives in cycle 1 (rdata 32'h1234_5678) -> imem_req low cycles 2-3; on wpcir=1, inst=32'h1234_5678 with no new request needed that cycle.
- Branch in decode with pcsource=01, bpc=32'h100, delay slot at pc=8 acked same cycle -> next imem_addr=32'h100; dpc4 of delay slot=12.
- Same branch but delay slot ack 2 cycles late -> redir_v set, pc stays 8 until ack, then imem_addr=32'h100; bpc change after latching has no effect.
- pcsource=10, ra=32'h0000_0203 -> next imem_addr=32'h0000_0200; clrn pulsed mid-wait -> imem_req=0 immediately, pc=RESET_PC, dvalid=0.
